// File: rtl/calc_pkg.sv
// Shared calculator display types: glyph codes, segment patterns and the glyph-to-segment map.
package calc_pkg;

    localparam int unsigned BIN_W   = 16;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned GLYPH_W = 4;
    localparam int unsigned N_BCD   = 5;
    localparam int unsigned N_DISP  = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

    typedef enum logic [GLYPH_W-1:0] {
        D0, D1, D2, D3, D4, D5, D6, D7, D8, D9, MINUS, BLANK, E
    } glyph_e;

    typedef logic [N_BCD-1:0][DIGIT_W-1:0]  bcd_t;
    typedef logic [N_DISP-1:0][GLYPH_W-1:0] disp_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;

    localparam disp_t DISP_BLANK = {N_DISP{GLYPH_W'(BLANK)}};

    function automatic logic [SEG_W-1:0] glyph_to_seg(input glyph_e g);
        logic [SEG_W-1:0] s;
        case (g)
            D0:      s = SEG_0;
            D1:      s = SEG_1;
            D2:      s = SEG_2;
            D3:      s = SEG_3;
            D4:      s = SEG_4;
            D5:      s = SEG_5;
            D6:      s = SEG_6;
            D7:      s = SEG_7;
            D8:      s = SEG_8;
            D9:      s = SEG_9;
            MINUS:   s = SEG_MINUS;
            E:       s = SEG_E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic glyph_e digit_glyph(input logic [DIGIT_W-1:0] d);
        return (d <= DIGIT_W'(9)) ? glyph_e'(d) : BLANK;
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle, MSB first.
module bcd_converter
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output bcd_t             bcd_o
);

    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam int unsigned FLAT_W = N_BCD * DIGIT_W;

    logic [BIN_W-1:0]  sr_q, sr_d;
    bcd_t              bcd_q, bcd_d, bcd_adj;
    logic [FLAT_W-1:0] adj_flat;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    // Add-3 correction on every digit that would overflow past 9 when doubled
    for (genvar g = 0; g < N_BCD; g++) begin : g_adj
        assign bcd_adj[g] = (bcd_q[g] >= DIGIT_W'(5)) ? bcd_q[g] + DIGIT_W'(3) : bcd_q[g];
    end
    assign adj_flat = bcd_adj;

    // done is raised during the final shift cycle so the caller can advance on the same edge
    always_comb begin
        sr_d   = sr_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start_i) begin
            sr_d  = bin_i;
            bcd_d = '0;
            cnt_d = CNT_W'(BIN_W);
        end else if (cnt_q != '0) begin
            sr_d   = {sr_q[BIN_W-2:0], 1'b0};
            bcd_d  = {adj_flat[FLAT_W-2:0], sr_q[BIN_W-1]};
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(2));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_display.sv
// Signed 16-bit value to multiplexed 4-digit seven-segment display with blanking,
// minus sign and overflow indication; conversion runs alongside a free-running digit scan.
module seg_display
    import calc_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic [SEG_W-1:0]  seg,
    output logic [N_DISP-1:0] an
);

    localparam int unsigned SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(N_DISP);

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic                busy_q, busy_d;
    disp_t               disp_q, disp_d, disp_new;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [N_DISP-1:0]   an_q, an_d;
    logic                start;
    logic                conv_done;
    logic [BIN_W-1:0]    mag;
    bcd_t                bcd;
    logic                nz1, nz2, nz3, ovf, wrap;

    assign start = (state_q == IDLE) && load;
    assign mag   = value[BIN_W-1] ? BIN_W'(~value + BIN_W'(1)) : value;

    bcd_converter u_conv (
        .clk     (clk),
        .rst     (reset),
        .start_i (start),
        .bin_i   (mag),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (conv_done) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Glyph image built from the finished BCD digits; written as a whole in COMMIT
    always_comb begin
        nz3 = (bcd[3] != '0);
        nz2 = nz3 || (bcd[2] != '0);
        nz1 = nz2 || (bcd[1] != '0);
        ovf = (bcd[4] != '0) || (sign_q && nz3);
        disp_new = DISP_BLANK;
        if (ovf) begin
            disp_new[0] = E;
        end else begin
            disp_new[0] = digit_glyph(bcd[0]);
            disp_new[1] = nz1 ? digit_glyph(bcd[1]) : BLANK;
            disp_new[2] = nz2 ? digit_glyph(bcd[2]) : BLANK;
            disp_new[3] = sign_q ? MINUS : (nz3 ? digit_glyph(bcd[3]) : BLANK);
        end
    end

    always_comb begin
        sign_d = start ? value[BIN_W-1] : sign_q;
        busy_d = (state_q != IDLE);
        disp_d = (state_q == COMMIT) ? disp_new : disp_q;
        wrap   = (scan_q == SCAN_W'(REFRESH_DIV - 1));
        scan_d = wrap ? '0 : scan_q + SCAN_W'(1);
        idx_d  = wrap ? idx_q + IDX_W'(1) : idx_q;
        an_d   = ~(N_DISP'(1) << idx_q);
        seg_d  = glyph_to_seg(glyph_e'(disp_d[idx_q]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            disp_q  <= DISP_BLANK;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            disp_q  <= disp_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign busy = busy_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_seg_display.sv
// Directed and random checks of seg_display against an arithmetic model of the displayed digits.
module tb_seg_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_MINUS = 7'b0111111;
    localparam logic [6:0] S_E     = 7'b0000110;

    seg_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .load  (load),
        .busy  (busy),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Expected segment pattern per digit position, [0] = rightmost
    function automatic logic [3:0][6:0] model(input int v);
        logic [3:0][6:0] r;
        int mag;
        int pw;
        bit neg;
        neg = (v < 0);
        mag = neg ? -v : v;
        for (int p = 0; p < 4; p++) r[p] = S_BLANK;
        if ((!neg && mag > 9999) || (neg && mag > 999)) begin
            r[0] = S_E;
        end else begin
            pw = 1;
            for (int p = 0; p < 4; p++) begin
                if (p == 0 || mag >= pw) r[p] = digit_seg((mag / pw) % 10);
                pw = pw * 10;
            end
            if (neg) r[3] = S_MINUS;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // Count busy cycles following the load edge, bounded
    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b1) n++;
            else break;
        end
    endtask

    // Watch one full scan period and compare each digit slot
    task automatic check_display(input string tag, input logic [3:0][6:0] exp);
        logic [3:0][6:0] seen;
        logic [3:0]      hit;
        logic            bad;
        seen = '1;
        hit  = '0;
        bad  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            case (an)
                4'b1110: begin seen[0] = seg; hit[0] = 1'b1; end
                4'b1101: begin seen[1] = seg; hit[1] = 1'b1; end
                4'b1011: begin seen[2] = seg; hit[2] = 1'b1; end
                4'b0111: begin seen[3] = seg; hit[3] = 1'b1; end
                default: bad = 1'b1;
            endcase
        end
        check($sformatf("%s_an_onehot", tag), {31'b0, bad}, 32'd0);
        check($sformatf("%s_slots", tag), {28'b0, hit}, 32'hf);
        for (int p = 0; p < 4; p++)
            check($sformatf("%s_d%0d", tag, p), {25'b0, seen[p]}, {25'b0, exp[p]});
    endtask

    task automatic convert(input string tag, input int v);
        int n;
        pulse_load(16'(v));
        check($sformatf("%s_busy_load_edge", tag), {31'b0, busy}, 32'd0);
        busy_len(n);
        check($sformatf("%s_busy_len", tag), n, 32'd17);
        check_display(tag, model(v));
    endtask

    initial begin
        int n;
        int v;
        logic seen_busy;
        logic [3:0] one;
        logic [3:0][6:0] all_blank;

        reset = 1'b1;
        value = '0;
        load  = 1'b0;
        #12;
        check("rst_seg", {25'b0, seg}, {25'b0, S_BLANK});
        check("rst_an", {28'b0, an}, 32'hf);
        check("rst_busy", {31'b0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("first_an", {28'b0, an}, 32'he);

        convert("v15", 15);
        convert("v16384", 16384);
        convert("vm999", -999);
        convert("vm1000", -1000);
        convert("v0", 0);
        convert("v9999", 9999);
        convert("vm32768", -32768);
        convert("v10000", 10000);
        convert("vm1", -1);
        convert("v32767", 32767);

        // Second load while busy must not disturb the conversion
        pulse_load(16'd2);
        for (int i = 0; i < 4; i++) tick();
        pulse_load(16'd77);
        busy_len(n);
        check("ignore_busy_rest", n, 32'd12);
        check_display("ignore", model(2));

        // Reset in the middle of SHIFT abandons the conversion
        pulse_load(16'd1234);
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        #1;
        check("midrst_seg", {25'b0, seg}, {25'b0, S_BLANK});
        check("midrst_an", {28'b0, an}, 32'hf);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen_busy |= busy;
        end
        check("midrst_no_busy", {31'b0, seen_busy}, 32'd0);
        for (int p = 0; p < 4; p++) all_blank[p] = S_BLANK;
        check_display("midrst_blank", all_blank);

        // Scan order and dwell, with a load in the middle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 5) begin
                value = 16'd42;
                load  = 1'b1;
            end
            tick();
            load = 1'b0;
            one = 4'b0001 << ((k / 4) % 4);
            check($sformatf("scan_k%0d", k), {28'b0, an}, {28'b0, ~one});
        end
        busy_len(n);
        check_display("scan_v42", model(42));

        // Random values, biased toward the interesting ranges
        for (int r = 0; r < 16; r++) begin
            case ($urandom_range(0, 3))
                0: v = int'($signed(16'($urandom)));
                1: v = int'($urandom_range(0, 9999));
                2: v = -int'($urandom_range(1, 999));
                default: v = int'($urandom_range(0, 2200)) - 1100;
            endcase
            convert($sformatf("rnd%0d", r), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
